// File: rtl/dmac_pkg.sv
// Shared definitions for the DMAC configuration master.
//   - Register offsets of the DMAC register-file slave (low nibble of the bus address).
//   - op_mode encodings carried in the MODE register.
//   - FSM state encoding of the configuration master.
//   - bus_addr(): forms a full 8-bit bus address from a base nibble and an offset.
package dmac_pkg;

  localparam logic [3:0] OFS_CLEAR = 4'd0;
  localparam logic [3:0] OFS_START = 4'd1;
  localparam logic [3:0] OFS_IEN   = 4'd2;
  localparam logic [3:0] OFS_SRC   = 4'd3;
  localparam logic [3:0] OFS_DEST  = 4'd4;
  localparam logic [3:0] OFS_PUSH  = 4'd5;
  localparam logic [3:0] OFS_DSIZE = 4'd6;
  localparam logic [3:0] OFS_DATA  = 4'd7;
  localparam logic [3:0] OFS_MODE  = 4'd8;
  localparam logic [3:0] OFS_DONE  = 4'd9;

  typedef enum logic [2:0] {
    OP_MEM2MEM = 3'd0,
    OP_MEM2PER = 3'd1,
    OP_PER2MEM = 3'd2,
    OP_PER2PER = 3'd3
  } op_mode_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_W_SRC,
    S_W_DEST,
    S_W_SIZE,
    S_W_PUSH,
    S_W_IEN,
    S_W_MODE,
    S_W_START,
    S_WAIT_IRQ,
    S_POLL_RD,
    S_POLL_CHK,
    S_W_CLEAR,
    S_DONE
  } state_e;

  function automatic logic [7:0] bus_addr(input logic [3:0] base, input logic [3:0] ofs);
    return {base, ofs};
  endfunction

endpackage

// File: rtl/dmac_cfg_master_if.sv
// Bus between the configuration master and the DMAC register-file slave.
//   M_sel     : bus cycle active
//   M_wr      : 1 = write, 0 = read
//   M_address : {base nibble, register offset}
//   M_dout    : write data, master to slave
//   M_din     : read data, slave to master (registered in the slave)
interface dmac_cfg_master_if;
  logic        M_sel;
  logic        M_wr;
  logic [7:0]  M_address;
  logic [31:0] M_dout;
  logic [31:0] M_din;

  modport master (output M_sel, output M_wr, output M_address, output M_dout, input M_din);
  modport slave  (input M_sel, input M_wr, input M_address, input M_dout, output M_din);
endinterface

// File: rtl/dmac_cfg_timer.sv
// Wait-state counter for the completion wait.
//   clk, reset_n : clock, synchronous active-low reset
//   clear        : restart counting from zero
//   en           : count this cycle (master is in a wait state)
//   expired      : the current cycle is wait cycle number LIMIT
module dmac_cfg_timer #(
  parameter int unsigned LIMIT = 1024
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int unsigned W = $clog2(LIMIT + 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  // Count is zero on the first wait cycle, so LIMIT-1 marks the last allowed one.
  assign expired = (count == W'(LIMIT - 1));

endmodule

// File: rtl/dmac_cfg_master.sv
// Bus initiator that programs and runs the DMAC register-file slave.
//   clk, reset_n                  : clock, synchronous active-low reset
//   desc_valid/desc_ready         : descriptor handshake (desc_src, desc_dest, desc_size)
//   start_valid/start_ready       : run request (start_mode, start_irq_en)
//   interrupt                     : completion interrupt from the slave
//   bus                           : master side of the register-file bus
//   busy                          : a descriptor push or run is in progress
//   desc_count                    : descriptors pushed since the last completed/aborted run
//   done, err_timeout, err_empty  : one-cycle status pulses
module dmac_cfg_master
  import dmac_pkg::*;
#(
  parameter logic [3:0]  BASE_ADDR      = 4'h0,
  parameter int unsigned MAX_DESC       = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    desc_valid,
  output logic                    desc_ready,
  input  logic [31:0]             desc_src,
  input  logic [31:0]             desc_dest,
  input  logic [31:0]             desc_size,
  input  logic                    start_valid,
  output logic                    start_ready,
  input  logic [2:0]              start_mode,
  input  logic                    start_irq_en,
  input  logic                    interrupt,
  dmac_cfg_master_if.master       bus,
  output logic                    busy,
  output logic [3:0]              desc_count,
  output logic                    done,
  output logic                    err_timeout,
  output logic                    err_empty
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_DESC);

  state_e      state_q, state_d;
  logic [31:0] src_q, dest_q, size_q;
  logic [2:0]  mode_q;
  logic        irq_en_q;
  logic [3:0]  count_q;
  logic        timeout_q, empty_q;

  logic        desc_acc, start_acc;
  logic        in_wait, completion, expired, timeout_hit, empty_hit;
  logic        unused_din;

  logic        sel, wr;
  logic [3:0]  ofs;
  logic [31:0] dout;

  assign desc_ready  = (state_q == S_IDLE) && (count_q < MAX_CNT);
  assign start_ready = (state_q == S_IDLE) && !desc_valid;
  assign desc_acc    = desc_valid && desc_ready;
  assign start_acc   = start_valid && start_ready;

  assign in_wait    = (state_q == S_WAIT_IRQ) || (state_q == S_POLL_RD) || (state_q == S_POLL_CHK);
  assign completion = ((state_q == S_WAIT_IRQ) && interrupt) ||
                      ((state_q == S_POLL_CHK) && bus.M_din[0]);
  // A completion on the limit cycle wins over the timeout.
  assign timeout_hit = in_wait && expired && !completion;
  assign empty_hit   = start_acc && (count_q == 4'd0);
  assign unused_din  = ^bus.M_din[31:1];

  dmac_cfg_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (state_q == S_W_START),
    .en      (in_wait),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      timeout_q <= 1'b0;
      empty_q   <= 1'b0;
      src_q     <= '0;
      dest_q    <= '0;
      size_q    <= '0;
      mode_q    <= '0;
      irq_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      timeout_q <= timeout_hit;
      empty_q   <= empty_hit;
      if (desc_acc) begin
        src_q  <= desc_src;
        dest_q <= desc_dest;
        size_q <= desc_size;
      end else if (start_acc) begin
        mode_q   <= start_mode;
        irq_en_q <= start_irq_en;
      end
      if ((state_q == S_DONE) || timeout_hit) begin
        count_q <= '0;
      end else if ((state_q == S_W_PUSH) && (count_q < MAX_CNT)) begin
        count_q <= count_q + 4'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (desc_acc) begin
          state_d = S_W_SRC;
        end else if (start_acc && !empty_hit) begin
          state_d = S_W_IEN;
        end
      end
      S_W_SRC:    state_d = S_W_DEST;
      S_W_DEST:   state_d = S_W_SIZE;
      S_W_SIZE:   state_d = S_W_PUSH;
      S_W_PUSH:   state_d = S_IDLE;
      S_W_IEN:    state_d = S_W_MODE;
      S_W_MODE:   state_d = S_W_START;
      S_W_START:  state_d = irq_en_q ? S_WAIT_IRQ : S_POLL_RD;
      S_WAIT_IRQ: begin
        if (completion)       state_d = S_W_CLEAR;
        else if (timeout_hit) state_d = S_IDLE;
      end
      S_POLL_RD:  state_d = timeout_hit ? S_IDLE : S_POLL_CHK;
      S_POLL_CHK: begin
        if (completion)       state_d = S_W_CLEAR;
        else if (timeout_hit) state_d = S_IDLE;
        else                  state_d = S_POLL_RD;
      end
      S_W_CLEAR:  state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Bus decode depends only on registered state and latched fields.
  always_comb begin
    sel  = 1'b0;
    wr   = 1'b0;
    ofs  = OFS_CLEAR;
    dout = '0;
    unique case (state_q)
      S_W_SRC:   begin sel = 1'b1; wr = 1'b1; ofs = OFS_SRC;   dout = src_q; end
      S_W_DEST:  begin sel = 1'b1; wr = 1'b1; ofs = OFS_DEST;  dout = dest_q; end
      // The slave takes the transfer size through its DATA offset.
      S_W_SIZE:  begin sel = 1'b1; wr = 1'b1; ofs = OFS_DATA;  dout = size_q; end
      S_W_PUSH:  begin sel = 1'b1; wr = 1'b1; ofs = OFS_PUSH;  dout = 32'h1; end
      S_W_IEN:   begin sel = 1'b1; wr = 1'b1; ofs = OFS_IEN;   dout = {31'b0, irq_en_q}; end
      S_W_MODE:  begin sel = 1'b1; wr = 1'b1; ofs = OFS_MODE;  dout = {29'b0, mode_q}; end
      S_W_START: begin sel = 1'b1; wr = 1'b1; ofs = OFS_START; dout = 32'h1; end
      S_POLL_RD: begin sel = 1'b1; wr = 1'b0; ofs = OFS_DONE; end
      S_W_CLEAR: begin sel = 1'b1; wr = 1'b1; ofs = OFS_CLEAR; dout = 32'h1; end
      default: ;
    endcase
  end

  assign bus.M_sel     = sel;
  assign bus.M_wr      = wr;
  assign bus.M_address = sel ? bus_addr(BASE_ADDR, ofs) : 8'h00;
  assign bus.M_dout    = dout;

  assign busy        = (state_q != S_IDLE);
  assign desc_count  = count_q;
  assign done        = (state_q == S_DONE);
  assign err_timeout = timeout_q;
  assign err_empty   = empty_q;

endmodule
